// File: rtl/analog_quad_encoder_pkg.sv
// Shared constants for the analog-to-quadrature paddle encoder.
// Phase codes are the literal {enc_a,enc_b} levels driven to the game.
package analog_quad_encoder_pkg;

   localparam logic [7:0] CENTRE = 8'h80;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   typedef enum logic [1:0] {
      DIR_HOLD = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_e;

endpackage

// File: rtl/analog_quad_encoder_tick_gen.sv
// Free-running step-rate divider: one-cycle tick every CLKDIV clocks.
// Runs regardless of enable so step timing stays on a fixed grid.
module quad_tick_gen #(
   parameter int CLKDIV = 5500
) (
   input  logic clk_sys,
   input  logic reset,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(CLKDIV - 1);

   logic [15:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/analog_quad_encoder.sv
// Tracks an absolute paddle/stick value and emits quadrature steps
// toward it, one step per divider tick, saturating at 0x00/0xFF.
module analog_quad_encoder
   import analog_quad_encoder_pkg::*;
#(
   parameter int CLKDIV   = 5500,
   parameter int DEADBAND = 1
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       enable,
   input  logic       signed_in,
   input  logic [7:0] target_in,
   output logic       enc_a,
   output logic       enc_b,
   output logic [7:0] pos,
   output logic       busy
);

   localparam logic [8:0] DB = 9'(DEADBAND);

   logic       tick;
   logic [7:0] tgt_q;
   logic [7:0] tgt_q2;
   logic [7:0] target_q;
   logic [7:0] pos_q;
   logic [1:0] phase_q;
   logic [1:0] phase_d;
   logic [8:0] diff_up;
   logic [8:0] diff_dn;
   logic       step_up;
   logic       step_dn;
   dir_e       dir;

   quad_tick_gen #(
      .CLKDIV (CLKDIV)
   ) u_tick (
      .clk_sys (clk_sys),
      .reset   (reset),
      .tick    (tick)
   );

   // Bit 8 set means the subtraction went negative.
   assign diff_up = {1'b0, target_q} - {1'b0, pos_q};
   assign diff_dn = {1'b0, pos_q} - {1'b0, target_q};

   assign step_up = !diff_up[8] && (diff_up > DB) && (pos_q != 8'hFF);
   assign step_dn = !diff_dn[8] && (diff_dn > DB) && (pos_q != 8'h00);

   assign busy  = step_up | step_dn;
   assign pos   = pos_q;
   assign enc_a = phase_q[1];
   assign enc_b = phase_q[0];

   always_comb begin
      dir = DIR_HOLD;
      unique case (1'b1)
         step_up: dir = DIR_UP;
         step_dn: dir = DIR_DN;
         default: dir = DIR_HOLD;
      endcase
   end

   always_comb begin
      phase_d = phase_q;
      unique case (phase_q)
         PH_00: phase_d = (dir == DIR_UP) ? PH_01 : PH_10;
         PH_01: phase_d = (dir == DIR_UP) ? PH_11 : PH_00;
         PH_11: phase_d = (dir == DIR_UP) ? PH_10 : PH_01;
         PH_10: phase_d = (dir == DIR_UP) ? PH_00 : PH_11;
         default: phase_d = PH_00;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tgt_q    <= CENTRE;
         tgt_q2   <= CENTRE;
         target_q <= CENTRE;
         pos_q    <= CENTRE;
         phase_q  <= PH_00;
      end else begin
         tgt_q  <= signed_in ? (target_in ^ CENTRE) : target_in;
         tgt_q2 <= tgt_q;
         // Two matching samples in a row reject single-cycle glitches.
         if (tgt_q == tgt_q2) begin
            target_q <= tgt_q;
         end
         if (tick && enable && (dir != DIR_HOLD)) begin
            pos_q   <= (dir == DIR_UP) ? pos_q + 8'd1 : pos_q - 8'd1;
            phase_q <= phase_d;
         end
      end
   end

endmodule

// File: tb/tb_analog_quad_encoder.sv
// Scoreboard bench for analog_quad_encoder with a fast divider.
// Expected steps are queued at stimulus time and popped per DUT step.
module tb_analog_quad_encoder;

   localparam int CLKDIV   = 4;
   localparam int DEADBAND = 1;

   typedef struct packed {
      logic [1:0] enc;
      logic [7:0] pos;
   } step_t;

   logic       clk_sys   = 1'b0;
   logic       reset     = 1'b1;
   logic       enable    = 1'b1;
   logic       signed_in = 1'b0;
   logic [7:0] target_in = 8'h80;
   logic       enc_a;
   logic       enc_b;
   logic [7:0] pos;
   logic       busy;

   step_t      sb_q[$];
   step_t      last_exp;
   int         chk_cnt = 0;
   int         pass_cnt = 0;
   bit         sb_on = 1'b1;
   logic [7:0] model_pos;
   logic [1:0] model_ph;

   analog_quad_encoder #(
      .CLKDIV   (CLKDIV),
      .DEADBAND (DEADBAND)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .enable    (enable),
      .signed_in (signed_in),
      .target_in (target_in),
      .enc_a     (enc_a),
      .enc_b     (enc_b),
      .pos       (pos),
      .busy      (busy)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic logic [1:0] gray_step(input logic [1:0] ph,
                                            input bit fwd);
      logic [1:0] seq [4];
      int idx;
      seq = '{2'b00, 2'b01, 2'b11, 2'b10};
      idx = 0;
      for (int i = 0; i < 4; i++) if (seq[i] == ph) idx = i;
      idx = fwd ? (idx + 1) % 4 : (idx + 3) % 4;
      return seq[idx];
   endfunction

   task automatic plan(input logic [7:0] tgt);
      bit fwd;
      while ((int'(tgt) - int'(model_pos) > DEADBAND) ||
             (int'(model_pos) - int'(tgt) > DEADBAND)) begin
         fwd = (tgt > model_pos);
         model_ph  = gray_step(model_ph, fwd);
         model_pos = fwd ? model_pos + 8'd1 : model_pos - 8'd1;
         sb_q.push_back('{enc: model_ph, pos: model_pos});
      end
   endtask

   task automatic drive(input logic s, input logic [7:0] t);
      @(posedge clk_sys);
      #1;
      signed_in = s;
      target_in = t;
   endtask

   task automatic do_reset();
      @(posedge clk_sys);
      #1;
      reset     = 1'b1;
      enable    = 1'b1;
      signed_in = 1'b0;
      target_in = 8'h80;
      repeat (2) @(posedge clk_sys);
      #1;
      reset     = 1'b0;
      model_pos = 8'h80;
      model_ph  = 2'b00;
   endtask

   task automatic wait_done(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk_sys);
         #1;
         if (sb_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Step monitor: every output change must be a legal single step.
   initial begin
      step_t prev;
      step_t cur;
      logic [1:0] shape;
      prev = '{enc: 2'b00, pos: 8'h80};
      forever begin
         @(negedge clk_sys);
         cur = {enc_a, enc_b, pos};
         if (reset) begin
            prev = cur;
            sb_q.delete();
         end else if (cur != prev) begin
            chk_cnt++;
            if (cur.pos == prev.pos + 8'd1)
               shape = gray_step(prev.enc, 1'b1);
            else if (cur.pos == prev.pos - 8'd1)
               shape = gray_step(prev.enc, 1'b0);
            else
               shape = ~cur.enc;
            if (cur.enc !== shape)
               $display("FAIL step_shape: got enc=%b pos=%h after enc=%b pos=%h",
                        cur.enc, cur.pos, prev.enc, prev.pos);
            else
               pass_cnt++;
            if (sb_on) begin
               chk_cnt++;
               if (sb_q.size() == 0) begin
                  $display("FAIL unexpected_step: got enc=%b pos=%h, none expected",
                           cur.enc, cur.pos);
               end else begin
                  last_exp = sb_q.pop_front();
                  if (cur !== last_exp)
                     $display("FAIL sb_step: got enc=%b pos=%h want enc=%b pos=%h",
                              cur.enc, cur.pos, last_exp.enc, last_exp.pos);
                  else
                     pass_cnt++;
               end
            end
            prev = cur;
         end
      end
   end

   task automatic test_reset();
      int busy_cycles;
      do_reset();
      chk_cnt++;
      if ({enc_a, enc_b, pos, busy} !== {2'b00, 8'h80, 1'b0})
         $display("FAIL reset_state: got enc=%b%b pos=%h busy=%b want 00 80 0",
                  enc_a, enc_b, pos, busy);
      else pass_cnt++;
      busy_cycles = 0;
      repeat (40) begin
         @(negedge clk_sys);
         if (busy) busy_cycles++;
      end
      chk_cnt++;
      if ({enc_a, enc_b, pos, busy_cycles} !== {2'b00, 8'h80, 32'd0})
         $display("FAIL reset_idle: got enc=%b%b pos=%h busy_cycles=%0d want 00 80 0",
                  enc_a, enc_b, pos, busy_cycles);
      else pass_cnt++;
   endtask

   task automatic test_forward();
      bit ok;
      do_reset();
      plan(8'h84);
      drive(1'b0, 8'h84);
      wait_done(200, ok);
      chk_cnt++;
      if (!ok) $display("FAIL fwd_timeout: got not idle want idle");
      else pass_cnt++;
      chk_cnt++;
      if ({enc_a, enc_b, pos, busy} !== {2'b10, 8'h83, 1'b0})
         $display("FAIL fwd_end: got enc=%b%b pos=%h busy=%b want 10 83 0",
                  enc_a, enc_b, pos, busy);
      else pass_cnt++;
   endtask

   task automatic test_reverse();
      bit ok;
      plan(8'h70);
      drive(1'b0, 8'h70);
      wait_done(400, ok);
      chk_cnt++;
      if (!ok) $display("FAIL rev_timeout: got not idle want idle");
      else pass_cnt++;
      chk_cnt++;
      if ({enc_a, enc_b, pos, busy} !== {2'b01, 8'h71, 1'b0})
         $display("FAIL rev_end: got enc=%b%b pos=%h busy=%b want 01 71 0",
                  enc_a, enc_b, pos, busy);
      else pass_cnt++;
   endtask

   task automatic test_saturate();
      bit ok;
      do_reset();
      plan(8'hFF);
      drive(1'b1, 8'h7F);
      wait_done(1000, ok);
      repeat (20) @(negedge clk_sys);
      chk_cnt++;
      if (!ok || {enc_a, enc_b, pos, busy} !== {2'b11, 8'hFE, 1'b0})
         $display("FAIL sat_high: got ok=%b enc=%b%b pos=%h busy=%b want 1 11 fe 0",
                  ok, enc_a, enc_b, pos, busy);
      else pass_cnt++;
      plan(8'h00);
      drive(1'b1, 8'h80);
      wait_done(1500, ok);
      repeat (20) @(negedge clk_sys);
      chk_cnt++;
      if (!ok || {enc_a, enc_b, pos, busy} !== {2'b01, 8'h01, 1'b0})
         $display("FAIL sat_low: got ok=%b enc=%b%b pos=%h busy=%b want 1 01 01 0",
                  ok, enc_a, enc_b, pos, busy);
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      int busy_cycles;
      do_reset();
      drive(1'b0, 8'hFF);
      drive(1'b0, 8'h80);
      busy_cycles = 0;
      repeat (40) begin
         @(negedge clk_sys);
         if (busy) busy_cycles++;
      end
      chk_cnt++;
      if ({enc_a, enc_b, pos, busy_cycles} !== {2'b00, 8'h80, 32'd0})
         $display("FAIL glitch: got enc=%b%b pos=%h busy_cycles=%0d want 00 80 0",
                  enc_a, enc_b, pos, busy_cycles);
      else pass_cnt++;
   endtask

   task automatic test_enable();
      bit ok;
      do_reset();
      plan(8'h88);
      drive(1'b0, 8'h88);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_sys);
         #1;
         if (sb_q.size() <= 5) begin
            ok = 1'b1;
            break;
         end
      end
      chk_cnt++;
      if (!ok) $display("FAIL en_start: got no steps want 2 steps");
      else pass_cnt++;
      @(posedge clk_sys);
      #1;
      enable = 1'b0;
      repeat (20) @(negedge clk_sys);
      chk_cnt++;
      if ({enc_a, enc_b, pos, busy} !== {last_exp.enc, last_exp.pos, 1'b1})
         $display("FAIL en_hold: got enc=%b%b pos=%h busy=%b want %b %h 1",
                  enc_a, enc_b, pos, busy, last_exp.enc, last_exp.pos);
      else pass_cnt++;
      enable = 1'b1;
      wait_done(200, ok);
      chk_cnt++;
      if (!ok || {enc_a, enc_b, pos} !== {2'b10, 8'h87})
         $display("FAIL en_resume: got ok=%b enc=%b%b pos=%h want 1 10 87",
                  ok, enc_a, enc_b, pos);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      plan(8'hFF);
      drive(1'b0, 8'hFF);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_sys);
         if (pos == 8'h90) begin
            ok = 1'b1;
            break;
         end
      end
      chk_cnt++;
      if (!ok) $display("FAIL rmid_reach: got pos=%h want 90", pos);
      else pass_cnt++;
      #1;
      reset     = 1'b1;
      target_in = 8'h80;
      @(posedge clk_sys);
      #1;
      chk_cnt++;
      if ({enc_a, enc_b, pos, busy, dut.u_tick.count} !==
          {2'b00, 8'h80, 1'b0, 16'd0})
         $display("FAIL rmid_state: got enc=%b%b pos=%h busy=%b div=%0d want 00 80 0 0",
                  enc_a, enc_b, pos, busy, dut.u_tick.count);
      else pass_cnt++;
      @(posedge clk_sys);
      #1;
      reset     = 1'b0;
      model_pos = 8'h80;
      model_ph  = 2'b00;
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [7:0] max_pos;
      do_reset();
      sb_on = 1'b0;
      drive(1'b0, 8'h90);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_sys);
         if (pos == 8'h84) begin
            ok = 1'b1;
            break;
         end
      end
      drive(1'b0, 8'h70);
      max_pos = pos;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk_sys);
         if (pos > max_pos) max_pos = pos;
         if (pos == 8'h71 && !busy) break;
      end
      repeat (20) @(negedge clk_sys);
      chk_cnt++;
      if (!ok || {pos, busy} !== {8'h71, 1'b0} || max_pos > 8'h88)
         $display("FAIL reversal: got ok=%b pos=%h busy=%b max=%h want 1 71 0 <=88",
                  ok, pos, busy, max_pos);
      else pass_cnt++;
      sb_on = 1'b1;
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_saturate();
      test_glitch();
      test_enable();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
